// File: rtl/modem_axil_pkg.sv
// modem_axil_pkg
//   Shared definitions for the AXI4-Lite command master.
//   - AXI response codes
//   - FSM state encoding
//   - width of one packed command record {write, addr, wdata, wstrb}
package modem_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } axil_state_t;

  function automatic int cmd_rec_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/axil_cmd_fifo.sv
// axil_cmd_fifo
//   Synchronous FIFO holding DEPTH command records. full/empty are
//   registered so the upstream ready never depends on this cycle's pop.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write side (ignored while full)
//   pop, pop_data     read side; pop_data shows the head entry (ignored while empty)
//   full, empty       registered status flags
module axil_cmd_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CNT_ONE;
    else if (!do_push && do_pop)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master
//   AXI4-Lite master sequencer. Commands are queued in axil_cmd_fifo and
//   issued one transaction at a time; each produces exactly one response.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command stream in
//   rsp_valid/ready/rdata/resp/timeout       response stream out
//   m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels
//   busy                         queue non-empty or transaction in flight
// Build option:
//   AXIL_MASTER_TIMEOUT_EN  enables a per-transaction watchdog of
//   TIMEOUT_CYCLES cycles; an expired transaction returns SLVERR with
//   rsp_timeout=1. Without it the FSM waits forever and rsp_timeout=0.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for a queued command; pops it on entry out
// ST_WR_REQ  | awvalid/wvalid up, each dropped on its own ready
// ST_WR_RESP | bready up, waiting for bvalid
// ST_RD_REQ  | arvalid up, waiting for arready
// ST_RD_RESP | rready up, waiting for rvalid
// ST_RSP     | rsp_valid up, holding response until rsp_ready
module axil_cmd_master
  import modem_axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int REC_W  = cmd_rec_width(ADDR_WIDTH, DATA_WIDTH);

  axil_state_t              state;
  logic [REC_W-1:0]         push_data;
  logic [REC_W-1:0]         pop_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     pop_write;
  logic [ADDR_WIDTH-1:0]    pop_addr;
  logic [DATA_WIDTH-1:0]    pop_wdata;
  logic [STRB_W-1:0]        pop_wstrb;
  logic                     aw_ok;
  logic                     w_ok;
  logic                     timeout_hit;

  assign push_data = {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
  assign pop_write = pop_data[REC_W-1];
  assign pop_addr  = pop_data[REC_W-2 -: ADDR_WIDTH];
  assign pop_wdata = pop_data[STRB_W +: DATA_WIDTH];
  assign pop_wstrb = pop_data[STRB_W-1:0];

  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // A channel counts as done once its valid is low or is being accepted now.
  assign aw_ok = !m_axi_awvalid || m_axi_awready;
  assign w_ok  = !m_axi_wvalid || m_axi_wready;

  axil_cmd_fifo #(
    .WIDTH (REC_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] wd_cnt;
  logic             tmo_flag;
  logic             xfer_done;

  // A handshake that completes on the expiry cycle wins over the abort.
  assign xfer_done = ((state == ST_WR_REQ)  && aw_ok && w_ok) ||
                     ((state == ST_WR_RESP) && m_axi_bvalid)  ||
                     ((state == ST_RD_REQ)  && m_axi_arready) ||
                     ((state == ST_RD_RESP) && m_axi_rvalid);
  assign timeout_hit = (state != ST_IDLE) && (state != ST_RSP) && (wd_cnt == TMO_LAST);
  assign rsp_timeout = tmo_flag;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
`ifdef AXIL_MASTER_TIMEOUT_EN
      wd_cnt        <= '0;
      tmo_flag      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (pop_write) begin
              m_axi_awaddr  <= pop_addr;
              m_axi_wdata   <= pop_wdata;
              m_axi_wstrb   <= pop_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= ST_WR_REQ;
            end else begin
              m_axi_araddr  <= pop_addr;
              m_axi_arvalid <= 1'b1;
              state         <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (m_axi_awvalid && m_axi_awready)
            m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)
            m_axi_wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Held at zero in IDLE so it starts from zero on the first active cycle.
      if (state == ST_IDLE) begin
        wd_cnt <= '0;
        if (!fifo_empty)
          tmo_flag <= 1'b0;
      end else if (state != ST_RSP) begin
        wd_cnt <= wd_cnt + TMO_ONE;
      end

      if (timeout_hit && !xfer_done) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_rdata     <= '0;
        rsp_resp      <= RESP_SLVERR;
        rsp_valid     <= 1'b1;
        tmo_flag      <= 1'b1;
        state         <= ST_RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
module tb_axil_cmd_master;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [12:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        busy;

  axil_cmd_master #(
    .ADDR_WIDTH(13), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model: addr[12]=1 is an error region ----------------
  logic [31:0] smem [0:2047];
  int  aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit  ar_block = 0, b_block = 0;
  int  aw_cnt, w_cnt, ar_cnt;
  logic aw_got, w_got;
  logic [12:0] aw_addr_l, last_araddr;
  logic [31:0] w_data_l;
  logic [3:0]  w_strb_l;
  int  aw_hs_cnt = 0, b_hs_cnt = 0, viol = 0;

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign wready  = wvalid && !w_got && (w_cnt >= w_delay);
  assign arready = arvalid && !ar_block && !rvalid && (ar_cnt >= ar_delay);

  wire        aw_hs = awvalid && awready;
  wire        w_hs  = wvalid && wready;
  wire        ar_hs = arvalid && arready;
  wire [12:0] eff_aw = aw_hs ? awaddr : aw_addr_l;
  wire [31:0] eff_wd = w_hs ? wdata : w_data_l;
  wire [3:0]  eff_ws = w_hs ? wstrb : w_strb_l;
  wire        wr_fire = (aw_got || aw_hs) && (w_got || w_hs) && !bvalid && !b_block;

  initial for (int i = 0; i < 2048; i++) smem[i] = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 0; w_got <= 0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      bvalid <= 0; rvalid <= 0;
    end else begin
      if (aw_hs) begin aw_got <= 1; aw_addr_l <= awaddr; aw_cnt <= 0; aw_hs_cnt <= aw_hs_cnt + 1; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1; w_data_l <= wdata; w_strb_l <= wstrb; w_cnt <= 0; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin bvalid <= 0; b_hs_cnt <= b_hs_cnt + 1; end
      if (wr_fire) begin
        aw_got <= 0; w_got <= 0; bvalid <= 1;
        bresp <= eff_aw[12] ? 2'b10 : 2'b00;
        if (!eff_aw[12])
          for (int b = 0; b < 4; b++)
            if (eff_ws[b]) smem[eff_aw[12:2]][8*b +: 8] <= eff_wd[8*b +: 8];
      end
      if (rvalid && rready) rvalid <= 0;
      if (ar_hs) begin
        rvalid <= 1; ar_cnt <= 0; last_araddr <= araddr;
        rdata <= araddr[12] ? 32'h0 : smem[araddr[12:2]];
        rresp <= araddr[12] ? 2'b10 : 2'b00;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // AXI stability: a pending valid must stay up with its payload unchanged.
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [12:0] p_awa, p_ara;
  logic [31:0] p_wd;
  always @(posedge clk) begin
    if (rst) begin
      p_awv <= 0; p_wv <= 0; p_arv <= 0;
    end else begin
      if (p_awv && !p_awr && (!awvalid || awaddr != p_awa)) viol <= viol + 1;
      if (p_wv && !p_wr && (!wvalid || wdata != p_wd)) viol <= viol + 1;
      if (!ar_block && p_arv && !p_arr && (!arvalid || araddr != p_ara)) viol <= viol + 1;
      if (awprot != 3'b000 || arprot != 3'b000) viol <= viol + 1;
      p_awv <= awvalid; p_awr <= awready; p_awa <= awaddr;
      p_wv <= wvalid; p_wr <= wready; p_wd <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input bit wr, input logic [12:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int unsigned hs_cyc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_bound", cmd_ready, 1);
    hs_cyc = cyc;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic get_rsp(output logic [31:0] rd, output logic [1:0] rs,
                         output logic to, output int unsigned rc);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_bound", rsp_valid, 1);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout; rc = cyc;
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  task automatic wait_sig_arvalid(output int unsigned c);
    int n = 0;
    while (!arvalid && n < 100) begin @(negedge clk); n++; end
    if (!arvalid) chk("arvalid_bound", arvalid, 1);
    c = cyc;
  endtask

  // ---------------- reference model for random phase ----------------
  typedef struct { logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t exp_q[$];
  logic [31:0] mdl [0:7];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    bit wr; logic [12:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] exp_rdata; logic [1:0] exp_resp;
  } vec_t;
  vec_t vt[12];

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int unsigned hc, rc, a0;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    int          awc, bc, n;

    vt[0]  = '{1, 13'h0004, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vt[1]  = '{0, 13'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{1, 13'h0008, 32'h11223344, 4'hF, 32'h0,        2'b00};
    vt[3]  = '{1, 13'h0008, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
    vt[4]  = '{0, 13'h0008, 32'h0,        4'h0, 32'h11BB33DD, 2'b00};
    vt[5]  = '{1, 13'h000C, 32'hCAFEF00D, 4'h8, 32'h0,        2'b00};
    vt[6]  = '{0, 13'h000C, 32'h0,        4'h0, 32'hCA000000, 2'b00};
    vt[7]  = '{1, 13'h1004, 32'h12345678, 4'hF, 32'h0,        2'b10};
    vt[8]  = '{0, 13'h1004, 32'h0,        4'h0, 32'h0,        2'b10};
    vt[9]  = '{0, 13'h0010, 32'h0,        4'h0, 32'h0,        2'b00};
    vt[10] = '{1, 13'h0004, 32'h00000000, 4'h0, 32'h0,        2'b00};
    vt[11] = '{0, 13'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    rst = 0;

    // table vectors, one command at a time
    for (int i = 0; i < 12; i++) begin
      awc = aw_hs_cnt;
      push(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, hc);
      get_rsp(rd, rs, to, rc);
      chk($sformatf("tbl%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("tbl%0d_resp", i), rs, vt[i].exp_resp);
      chk($sformatf("tbl%0d_timeout", i), to, 0);
      if (i == 0) begin
        chk("wr_latency", rc - hc, 4);
        chk("wr_single_aw", aw_hs_cnt - awc, 1);
      end
      if (i == 1) begin
        chk("rd_latency", rc - hc, 4);
        chk("rd_araddr", last_araddr, 13'h0004);
      end
    end

    // five commands queued behind a stalled response
    push(1, 13'h0100, 32'h00000001, 4'hF, hc);
    push(0, 13'h0100, 32'h0, 4'h0, hc);
    push(1, 13'h0104, 32'h00000002, 4'hF, hc);
    push(0, 13'h0104, 32'h0, 4'h0, hc);
    push(0, 13'h0100, 32'h0, 4'h0, hc);
    repeat (4) @(negedge clk);
    chk("fill_cmd_ready", cmd_ready, 0);
    chk("fill_busy", busy, 1);
    chk("fill_rsp_valid", rsp_valid, 1);
    get_rsp(rd, rs, to, rc); chk("fill0_rdata", rd, 32'h0);
    get_rsp(rd, rs, to, rc); chk("fill1_rdata", rd, 32'h1);
    get_rsp(rd, rs, to, rc); chk("fill2_rdata", rd, 32'h0);
    get_rsp(rd, rs, to, rc); chk("fill3_rdata", rd, 32'h2);
    get_rsp(rd, rs, to, rc); chk("fill4_rdata", rd, 32'h1);
    repeat (3) @(negedge clk);
    chk("fill_drained_busy", busy, 0);

    // awready delayed 3 cycles, wready immediate
    aw_delay = 3; w_delay = 0; bc = b_hs_cnt;
    push(1, 13'h0200, 32'h55AA55AA, 4'hF, hc);
    n = 0;
    while (!awvalid && n < 50) begin @(negedge clk); n++; end
    chk("dly_first_wvalid", {awvalid, wvalid}, 2'b11);
    @(negedge clk);
    chk("dly_second_cycle", {awvalid, wvalid}, 2'b10);
    n = 1;
    while (awvalid && n < 50) begin @(negedge clk); n++; end
    chk("dly_awvalid_cycles", n, 4);
    get_rsp(rd, rs, to, rc);
    chk("dly_resp", rs, 2'b00);
    chk("dly_single_b", b_hs_cnt - bc, 1);
    aw_delay = 0;
    push(0, 13'h0200, 32'h0, 4'h0, hc);
    get_rsp(rd, rs, to, rc);
    chk("dly_readback", rd, 32'h55AA55AA);

`ifdef AXIL_MASTER_TIMEOUT_EN
    ar_block = 1;
    push(0, 13'h0300, 32'h0, 4'h0, hc);
    wait_sig_arvalid(a0);
    get_rsp(rd, rs, to, rc);
    chk("tmo_cycles", rc - a0, 16);
    chk("tmo_resp", rs, 2'b10);
    chk("tmo_flag", to, 1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_arvalid_dropped", arvalid, 0);
    ar_block = 0;
`endif

    // randomized traffic against the model
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          bit          w = 1'($urandom_range(0, 1));
          bit          e = ($urandom_range(0, 7) == 0);
          logic [12:0] a = 13'h0800 | 13'($urandom_range(0, 7) << 2) | (e ? 13'h1000 : 13'h0);
          logic [31:0] d = $urandom;
          logic [3:0]  s = 4'($urandom_range(0, 15));
          exp_t        x;
          int unsigned h;
          if (e)      begin x.rdata = 32'h0; x.resp = 2'b10; end
          else if (w) begin x.rdata = 32'h0; x.resp = 2'b00; mdl[a[4:2]] = merge(mdl[a[4:2]], d, s); end
          else        begin x.rdata = mdl[a[4:2]]; x.resp = 2'b00; end
          exp_q.push_back(x);
          aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2); ar_delay = $urandom_range(0, 2);
          push(w, a, d, s, h);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        int   got = 0, guard = 0;
        exp_t x;
        while (got < 60 && guard < 20000) begin
          @(negedge clk);
          guard++;
          rsp_ready = 1'($urandom_range(0, 1));
          if (rsp_valid && rsp_ready) begin
            x = exp_q.pop_front();
            chk($sformatf("rnd%0d_rdata", got), rsp_rdata, x.rdata);
            chk($sformatf("rnd%0d_resp", got), rsp_resp, x.resp);
            got++;
          end
        end
        @(posedge clk);
        #1 rsp_ready = 0;
        chk("rnd_count", got, 60);
      end
    join
    aw_delay = 0; w_delay = 0; ar_delay = 0;

    // reset while waiting for B
    b_block = 1;
    push(1, 13'h0400, 32'h0BADF00D, 4'hF, hc);
    n = 0;
    @(negedge clk);
    while (!bready && n < 50) begin @(negedge clk); n++; end
    chk("rst6_in_wr_resp", bready, 1);
    rst = 1;
    @(negedge clk);
    chk("rst6_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("rst6_cmd_ready", cmd_ready, 1);
    chk("rst6_busy", busy, 0);
    rst = 0; b_block = 0;
    repeat (5) @(negedge clk);
    chk("rst6_no_rsp", rsp_valid, 0);
    push(0, 13'h0004, 32'h0, 4'h0, hc);
    get_rsp(rd, rs, to, rc);
    chk("rst6_after_read", rd, 32'hDEADBEEF);

    chk("axi_stable_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
